execute_mc: RTL and testbench
=============================

// Module: execute_mc
// PURPOSE
// - Parametrised multi-cycle execute stage: register file, ALU, flag register, jump decode and PC, plus a memory-access FSM.
// - Sits after decode; stalls the pipeline via o_ready while a load/store (or optional multiply) is in flight.
// - Sends o_pc_update/o_exec_pc to fetch on every committed instruction for misprediction recovery.
// PARAMETERS
// - RW      16  datapath, register, address and PC width (>=8)
// - REGNO   8   number of general registers (power of 2, >=2); RSEL = $clog2(REGNO)
// PORTS
// - i_clk              in   1      clock
// - i_rst              in   1      reset, synchronous, active-high
// - o_ready            out  1      stage idle; i_submit is accepted only when high
// - i_submit           in   1      valid instruction this cycle; low = bubble, no state change
// - i_imm              in   RW     immediate operand
// - c_pc_inc, c_pc_ie  in   1,1    PC += 1 / PC <= ALU result
// - c_r_bus_imm        in   1      ALU right operand = i_imm instead of R register
// - c_alu_mode         in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL1,6 SHR1,7 PASS_R,8 MUL (macro)
// - c_alu_carry_en     in   1      ADD/SUB use stored C as carry/borrow in
// - c_alu_flags_ie     in   1      update flags {P,O,N,Z,C} on commit
// - c_l_reg_sel, c_r_reg_sel in RSEL  register read selects
// - c_rf_ie            in   REGNO  one-hot-or-more register write enables
// - c_jump_cond_code   in   5      bit4 = jump valid; [3:0] 0 UNCOND,1 C,2 Z,3 N(LT),4 GT,5 LE,6 GE,7 NE,8 O,9 P
// - c_mem_rd, c_mem_wr in   1,1    instruction is a load / store
// - o_mem_req          out  1      memory request, held until i_mem_ack
// - o_mem_we           out  1      request is a write
// - o_mem_addr         out  RW     address = ALU result at submit
// - o_mem_data         out  RW     store data = R register value at submit
// - i_mem_data         in   RW     load data, valid with i_mem_ack
// - i_mem_ack          in   1      memory done (single cycle pulse)
// - o_pc_update        out  1      registered, 1-cycle pulse after every commit
// - o_exec_pc          out  RW     PC register value
// - dbg_r0, dbg_pc     out  RW     register 0, PC
// BEHAVIOUR
// - Reset: all registers, flags, PC = 0; state IDLE; o_ready=1; o_mem_req/o_mem_we/o_pc_update=0; addr/data=0.
// - Reset mid-operation: FSM to IDLE on the same edge, request dropped, nothing committed.
// - FSM IDLE / MEM / MUL. i_submit while o_ready=0 is ignored.
// - IDLE + i_submit, no mem/mul: commit same edge: ALU result to every reg with c_rf_ie set, flags if ie, PC update.
// - IDLE + i_submit + mem: latch ctrl, addr, data, we (c_mem_wr wins if both set); -> MEM; o_req=1, o_ready=0 next cycle.
// - MEM: hold outputs stable; on i_mem_ack commit (load: i_mem_data to c_rf_ie regs; flags never updated), PC += 1,
//   drop o_mem_req same edge, -> IDLE. Ack in the request-issue cycle is ignored (req not yet high).
// - Jump: taken = valid & cond(flags_q) -> PC <= ALU result; valid & not taken -> PC += 1; else c_pc_ie / c_pc_inc.
// - Flags: C carry-out (ADD) / borrow (SUB) / shifted-out bit; Z result==0; N result[RW-1];
//   O signed overflow (ADD/SUB, else 0); P even parity of result. Unused mode codes: result 0.
// - Arithmetic modulo 2^RW; PC wraps 2^RW-1 -> 0.
// - o_pc_update=1 the cycle after each commit; o_exec_pc then shows the new PC.
// CONFIGURATION
// - EXECUTE_MUL_EN defined: mode 8 = unsigned shift-add multiply, state MUL, RW cycles after submit, o_ready=0;
//   commits low RW bits; flags Z,N,P from result, C=O=0; PC += 1.
// - Not defined: mode 8 behaves as an unused code (single cycle, result 0); no MUL state.
// TESTING (RW=16, REGNO=8)
// - r1=5,r2=7, ADD r3=r1+r2, flags_ie -> r3=12, Z=0,C=0, PC 0->1, o_pc_update pulse next cycle.
// - 0xFFFF ADD imm 1 -> result 0, C=1, Z=1, P=1; then jump code 10010, ALU=0x0040 -> PC=0x0040.
// - Load r4 from r1+imm 0x10 (r1=0x20): o_mem_addr=0x30, o_ready=0, ack after 3 cycles with 0xBEEF -> r4=0xBEEF.
// - Store with i_submit pulsed again during MEM -> second submit ignored, o_req held, no reg/PC change till ack.
// - i_rst during MEM -> o_mem_req=0, o_ready=1, PC=0 next cycle; late i_mem_ack ignored.
// - EXECUTE_MUL_EN: 300*300 -> r5=0x5F90, o_ready low 16 cycles; without macro mode 8 -> r5=0, Z=1.

Source files
------------

// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage (register file, ALU, flags, jump/PC, load/store FSM).
// Define EXECUTE_MUL_EN to add the iterative shift-add multiply on ALU mode 8.
module execute_mc #(
    parameter int  RW    = 16,
    parameter int  REGNO = 8,
    localparam int RSEL  = $clog2(REGNO)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_ready,
    input  logic             i_submit,
    input  logic [RW-1:0]    i_imm,
    input  logic             c_pc_inc,
    input  logic             c_pc_ie,
    input  logic             c_r_bus_imm,
    input  logic [3:0]       c_alu_mode,
    input  logic             c_alu_carry_en,
    input  logic             c_alu_flags_ie,
    input  logic [RSEL-1:0]  c_l_reg_sel,
    input  logic [RSEL-1:0]  c_r_reg_sel,
    input  logic [REGNO-1:0] c_rf_ie,
    input  logic [4:0]       c_jump_cond_code,
    input  logic             c_mem_rd,
    input  logic             c_mem_wr,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    input  logic [RW-1:0]    i_mem_data,
    input  logic             i_mem_ack,
    output logic             o_pc_update,
    output logic [RW-1:0]    o_exec_pc,
    output logic [RW-1:0]    dbg_r0,
    output logic [RW-1:0]    dbg_pc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
`ifdef EXECUTE_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam int         CNT_W   = $clog2(RW);
`endif

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;

    // Flag vector layout {P,O,N,Z,C}
    localparam int F_C = 0, F_Z = 1, F_N = 2, F_O = 3, F_P = 4;

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    regs_q [REGNO];
    logic [RW-1:0]    regs_d [REGNO];
    logic [4:0]       flags_q, flags_d;
    logic [RW-1:0]    pc_q, pc_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [RW-1:0]    mem_addr_q, mem_addr_d;
    logic [RW-1:0]    mem_data_q, mem_data_d;
    logic [REGNO-1:0] rf_ie_q, rf_ie_d;
    logic             pc_update_q, pc_update_d;
`ifdef EXECUTE_MUL_EN
    logic             mul_fie_q, mul_fie_d;
    logic [RW-1:0]    mul_acc_q, mul_acc_d;
    logic [RW-1:0]    mul_mcand_q, mul_mcand_d;
    logic [RW-1:0]    mul_mplier_q, mul_mplier_d;
    logic [RW-1:0]    mul_sum;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
`endif

    logic [RW-1:0] l_op, r_reg, r_op, alu_res, pc_plus1;
    logic [RW:0]   ext;
    logic          cin, alu_c, alu_o, jump_taken;

    function automatic logic [4:0] mk_flags(input logic [RW-1:0] res, input logic c, input logic o);
        return {~^res, o, res[RW-1], (res == '0), c};
    endfunction

    // LT/GE/GT/LE are judged on N (and Z) alone, not N^O
    function automatic logic cond_met(input logic [3:0] code, input logic [4:0] f);
        logic met;
        met = 1'b0;
        case (code)
            4'd0: met = 1'b1;
            4'd1: met = f[F_C];
            4'd2: met = f[F_Z];
            4'd3: met = f[F_N];
            4'd4: met = ~f[F_N] & ~f[F_Z];
            4'd5: met = f[F_N] | f[F_Z];
            4'd6: met = ~f[F_N];
            4'd7: met = ~f[F_Z];
            4'd8: met = f[F_O];
            4'd9: met = f[F_P];
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    always_comb begin
        l_op     = regs_q[c_l_reg_sel];
        r_reg    = regs_q[c_r_reg_sel];
        r_op     = c_r_bus_imm ? i_imm : r_reg;
        cin      = c_alu_carry_en & flags_q[F_C];
        pc_plus1 = pc_q + RW'(1);
        ext      = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_o    = 1'b0;
        case (c_alu_mode)
            ALU_ADD: begin
                ext     = {1'b0, l_op} + {1'b0, r_op} + (RW+1)'(cin);
                alu_res = ext[RW-1:0];
                alu_c   = ext[RW];
                alu_o   = (l_op[RW-1] == r_op[RW-1]) && (alu_res[RW-1] != l_op[RW-1]);
            end
            ALU_SUB: begin
                ext     = {1'b0, l_op} - {1'b0, r_op} - (RW+1)'(cin);
                alu_res = ext[RW-1:0];
                alu_c   = ext[RW];
                alu_o   = (l_op[RW-1] != r_op[RW-1]) && (alu_res[RW-1] != l_op[RW-1]);
            end
            ALU_AND:  alu_res = l_op & r_op;
            ALU_OR:   alu_res = l_op | r_op;
            ALU_XOR:  alu_res = l_op ^ r_op;
            ALU_SHL: begin
                alu_res = {l_op[RW-2:0], 1'b0};
                alu_c   = l_op[RW-1];
            end
            ALU_SHR: begin
                alu_res = {1'b0, l_op[RW-1:1]};
                alu_c   = l_op[0];
            end
            ALU_PASS: alu_res = r_op;
            default:  alu_res = '0;
        endcase
        jump_taken = c_jump_cond_code[4] & cond_met(c_jump_cond_code[3:0], flags_q);
    end

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no path infers a latch.
        state_d     = state_q;
        regs_d      = regs_q;
        flags_d     = flags_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        rf_ie_d     = rf_ie_q;
        pc_update_d = 1'b0;
`ifdef EXECUTE_MUL_EN
        mul_fie_d    = mul_fie_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        mul_sum      = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_submit) begin
                    if (c_mem_rd | c_mem_wr) begin
                        state_d    = ST_MEM;
                        mem_req_d  = 1'b1;
                        mem_we_d   = c_mem_wr;
                        mem_addr_d = alu_res;
                        mem_data_d = r_reg;
                        rf_ie_d    = c_rf_ie;
                    end
`ifdef EXECUTE_MUL_EN
                    else if (c_alu_mode == ALU_MUL) begin
                        state_d      = ST_MUL;
                        rf_ie_d      = c_rf_ie;
                        mul_fie_d    = c_alu_flags_ie;
                        mul_acc_d    = '0;
                        mul_mcand_d  = l_op;
                        mul_mplier_d = r_op;
                        mul_cnt_d    = '0;
                    end
`endif
                    else begin
                        for (int i = 0; i < REGNO; i++)
                            if (c_rf_ie[i]) regs_d[i] = alu_res;
                        if (c_alu_flags_ie) flags_d = mk_flags(alu_res, alu_c, alu_o);
                        if (c_jump_cond_code[4]) pc_d = jump_taken ? alu_res : pc_plus1;
                        else if (c_pc_ie)        pc_d = alu_res;
                        else if (c_pc_inc)       pc_d = pc_plus1;
                        pc_update_d = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    if (!mem_we_q)
                        for (int i = 0; i < REGNO; i++)
                            if (rf_ie_q[i]) regs_d[i] = i_mem_data;
                    pc_d        = pc_plus1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    state_d     = ST_IDLE;
                    pc_update_d = 1'b1;
                end
            end
`ifdef EXECUTE_MUL_EN
            ST_MUL: begin
                mul_acc_d    = mul_sum;
                mul_mcand_d  = {mul_mcand_q[RW-2:0], 1'b0};
                mul_mplier_d = {1'b0, mul_mplier_q[RW-1:1]};
                mul_cnt_d    = mul_cnt_q + CNT_W'(1);
                if (mul_cnt_q == CNT_W'(RW-1)) begin
                    for (int i = 0; i < REGNO; i++)
                        if (rf_ie_q[i]) regs_d[i] = mul_sum;
                    if (mul_fie_q) flags_d = mk_flags(mul_sum, 1'b0, 1'b0);
                    pc_d        = pc_plus1;
                    state_d     = ST_IDLE;
                    pc_update_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            flags_q     <= '0;
            pc_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rf_ie_q     <= '0;
            pc_update_q <= 1'b0;
            // NOTE: the register file is plain flops, not a RAM macro, so it resets like other state.
            for (int i = 0; i < REGNO; i++) regs_q[i] <= '0;
`ifdef EXECUTE_MUL_EN
            mul_fie_q    <= 1'b0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rf_ie_q     <= rf_ie_d;
            pc_update_q <= pc_update_d;
`ifdef EXECUTE_MUL_EN
            mul_fie_q    <= mul_fie_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
`endif
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_pc_update = pc_update_q;
    assign o_exec_pc   = pc_q;
    assign dbg_r0      = regs_q[0];
    assign dbg_pc      = pc_q;

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc (RW=16, REGNO=8): directed scenarios plus random
// stimulus compared every cycle against a transaction-level model. Honours EXECUTE_MUL_EN.
module tb_execute_mc;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_ready;
    logic        i_submit;
    logic [15:0] i_imm;
    logic        c_pc_inc, c_pc_ie, c_r_bus_imm;
    logic [3:0]  c_alu_mode;
    logic        c_alu_carry_en, c_alu_flags_ie;
    logic [2:0]  c_l_reg_sel, c_r_reg_sel;
    logic [7:0]  c_rf_ie;
    logic [4:0]  c_jump_cond_code;
    logic        c_mem_rd, c_mem_wr;
    logic        o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr, o_mem_data, i_mem_data;
    logic        i_mem_ack;
    logic        o_pc_update;
    logic [15:0] o_exec_pc, dbg_r0, dbg_pc;

    execute_mc #(.RW(16), .REGNO(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready), .i_submit(i_submit), .i_imm(i_imm),
        .c_pc_inc(c_pc_inc), .c_pc_ie(c_pc_ie), .c_r_bus_imm(c_r_bus_imm), .c_alu_mode(c_alu_mode),
        .c_alu_carry_en(c_alu_carry_en), .c_alu_flags_ie(c_alu_flags_ie),
        .c_l_reg_sel(c_l_reg_sel), .c_r_reg_sel(c_r_reg_sel), .c_rf_ie(c_rf_ie),
        .c_jump_cond_code(c_jump_cond_code), .c_mem_rd(c_mem_rd), .c_mem_wr(c_mem_wr),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .i_mem_data(i_mem_data), .i_mem_ack(i_mem_ack), .o_pc_update(o_pc_update),
        .o_exec_pc(o_exec_pc), .dbg_r0(dbg_r0), .dbg_pc(dbg_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0] imm;
        logic        pc_inc, pc_ie, bus_imm;
        logic [3:0]  mode;
        logic        cen, fie;
        logic [2:0]  lsel, rsel;
        logic [7:0]  rf_ie;
        logic [4:0]  jcc;
        logic        rd, wr;
    } instr_t;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_reg [8];
    bit          m_c, m_z, m_n, m_o, m_p;
    logic [15:0] m_pc;
    int          m_kind;        // 0 idle, 1 memory access pending, 2 multiply pending
    bit          m_we;
    logic [15:0] m_addr, m_data, m_prod;
    logic [7:0]  m_rfie;
    bit          m_fie, m_upd;
    int          m_left;

    function automatic int sgn(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic void alu_model(input int mode, input int unsigned l, input int unsigned r,
                                      input bit cin, output int unsigned res, output bit c, output bit o);
        int s;
        res = 0; c = 0; o = 0;
        case (mode)
            0: begin
                res = (l + r + cin) % 65536;  c = (l + r + cin) >= 65536;
                s = sgn(l) + sgn(r) + int'(cin); o = (s > 32767) || (s < -32768);
            end
            1: begin
                s = int'(l) - int'(r) - int'(cin); c = s < 0; res = int'(s + 131072) % 65536;
                s = sgn(l) - sgn(r) - int'(cin); o = (s > 32767) || (s < -32768);
            end
            2: res = l & r;
            3: res = l | r;
            4: res = l ^ r;
            5: begin res = (l * 2) % 65536; c = l >= 32768; end
            6: begin res = l / 2; c = (l % 2) == 1; end
            7: res = r;
`ifdef EXECUTE_MUL_EN
            8: res = (l * r) % 65536;
`endif
            default: res = 0;
        endcase
    endfunction

    function automatic bit jump_cond(input int code);
        case (code)
            0: return 1'b1;
            1: return m_c;
            2: return m_z;
            3: return m_n;
            4: return !m_n && !m_z;
            5: return m_n || m_z;
            6: return !m_n;
            7: return !m_z;
            8: return m_o;
            9: return m_p;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_flags(input int unsigned res, input bit c, input bit o);
        m_c = c; m_o = o; m_z = (res == 0); m_n = (res >= 32768);
        m_p = ($countones(res) % 2) == 0;
    endtask

    always @(posedge i_clk) begin : model
        int unsigned l, r, res;
        bit c, o, taken;
        m_upd = 1'b0;
        if (i_rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
            m_c = 0; m_z = 0; m_n = 0; m_o = 0; m_p = 0;
            m_pc = 16'h0; m_kind = 0; m_we = 0; m_addr = 16'h0; m_data = 16'h0;
        end else if (m_kind == 0) begin
            if (i_submit) begin
                l = m_reg[c_l_reg_sel];
                r = c_r_bus_imm ? i_imm : m_reg[c_r_reg_sel];
                alu_model(int'(c_alu_mode), l, r, c_alu_carry_en && m_c, res, c, o);
                if (c_mem_rd || c_mem_wr) begin
                    m_kind = 1; m_we = c_mem_wr; m_addr = 16'(res);
                    m_data = m_reg[c_r_reg_sel]; m_rfie = c_rf_ie;
                end
`ifdef EXECUTE_MUL_EN
                else if (c_alu_mode == 4'd8) begin
                    m_kind = 2; m_left = 16; m_prod = 16'(res); m_rfie = c_rf_ie; m_fie = c_alu_flags_ie;
                end
`endif
                else begin
                    taken = jump_cond(int'(c_jump_cond_code[3:0]));
                    for (int i = 0; i < 8; i++) if (c_rf_ie[i]) m_reg[i] = 16'(res);
                    if (c_alu_flags_ie) set_flags(res, c, o);
                    if (c_jump_cond_code[4]) m_pc = taken ? 16'(res) : m_pc + 16'd1;
                    else if (c_pc_ie)        m_pc = 16'(res);
                    else if (c_pc_inc)       m_pc = m_pc + 16'd1;
                    m_upd = 1'b1;
                end
            end
        end else if (m_kind == 1) begin
            if (i_mem_ack) begin
                if (!m_we) for (int i = 0; i < 8; i++) if (m_rfie[i]) m_reg[i] = i_mem_data;
                m_pc = m_pc + 16'd1; m_kind = 0; m_upd = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                for (int i = 0; i < 8; i++) if (m_rfie[i]) m_reg[i] = m_prod;
                if (m_fie) set_flags(m_prod, 1'b0, 1'b0);
                m_pc = m_pc + 16'd1; m_kind = 0; m_upd = 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("ready", o_ready, m_kind == 0);
            check("mem_req", o_mem_req, m_kind == 1);
            check("mem_we", o_mem_we, (m_kind == 1) && m_we);
            if (m_kind == 1) begin
                check("mem_addr", o_mem_addr, m_addr);
                check("mem_data", o_mem_data, m_data);
            end
            check("pc_update", o_pc_update, m_upd);
            check("exec_pc", o_exec_pc, m_pc);
            check("dbg_pc", dbg_pc, m_pc);
            check("dbg_r0", dbg_r0, m_reg[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply(input instr_t x);
        i_imm = x.imm; c_pc_inc = x.pc_inc; c_pc_ie = x.pc_ie; c_r_bus_imm = x.bus_imm;
        c_alu_mode = x.mode; c_alu_carry_en = x.cen; c_alu_flags_ie = x.fie;
        c_l_reg_sel = x.lsel; c_r_reg_sel = x.rsel; c_rf_ie = x.rf_ie;
        c_jump_cond_code = x.jcc; c_mem_rd = x.rd; c_mem_wr = x.wr;
    endtask

    task automatic send(input instr_t x);
        apply(x);
        i_submit = 1'b1;
        step();
        i_submit = 1'b0;
        i_mem_ack = 1'b0;
    endtask

    function automatic instr_t mk(input logic [3:0] mode, input logic bus_imm, input logic [15:0] imm,
                                  input logic [2:0] ls, input logic [2:0] rs, input logic [7:0] rf,
                                  input logic fie, input logic [4:0] jcc);
        instr_t x;
        x = '0;
        x.mode = mode; x.bus_imm = bus_imm; x.imm = imm; x.lsel = ls; x.rsel = rs;
        x.rf_ie = rf; x.fie = fie; x.jcc = jcc; x.pc_inc = 1'b1;
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        case ($urandom_range(0, 5))
            0: x.imm = 16'h0000;
            1: x.imm = 16'hFFFF;
            2: x.imm = 16'h7FFF;
            3: x.imm = 16'h8000;
            4: x.imm = 16'h0001;
            default: x.imm = 16'($urandom);
        endcase
        x.pc_inc  = 1'($urandom_range(0, 1));
        x.pc_ie   = ($urandom_range(0, 5) == 0);
        x.bus_imm = 1'($urandom_range(0, 1));
        x.mode    = ($urandom_range(0, 9) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
        x.cen     = 1'($urandom_range(0, 1));
        x.fie     = ($urandom_range(0, 3) != 0);
        x.lsel    = 3'($urandom_range(0, 7));
        x.rsel    = 3'($urandom_range(0, 7));
        x.rf_ie   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        x.jcc     = ($urandom_range(0, 3) == 0) ? {1'b1, 4'($urandom_range(0, 11))}
                                                 : {1'b0, 4'($urandom_range(0, 15))};
        x.rd      = ($urandom_range(0, 7) == 0);
        x.wr      = ($urandom_range(0, 7) == 0);
        return x;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        instr_t x;
        i_rst = 1'b1; i_submit = 1'b0; i_mem_ack = 1'b0; i_mem_data = 16'h0;
        apply('0);
        step(); step();
        i_rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_ready", o_ready, 1);
        check("rst_req", o_mem_req, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_pc", o_exec_pc, 16'h0);
        check("rst_r0", dbg_r0, 16'h0);
        check("rst_pc_update", o_pc_update, 0);

        // r1=5, r2=7, r3=r0=r1+r2 with flags
        send(mk(4'd7, 1, 16'd5, 0, 0, 8'h02, 0, 5'b0));
        check("first_pc", o_exec_pc, 16'h1);
        check("first_pc_update", o_pc_update, 1);
        send(mk(4'd7, 1, 16'd7, 0, 0, 8'h04, 0, 5'b0));
        send(mk(4'd0, 0, 16'd0, 1, 2, 8'h09, 1, 5'b0));
        check("add_r0", dbg_r0, 16'd12);
        check("add_pc", o_exec_pc, 16'd3);
        step();
        check("pc_update_drop", o_pc_update, 0);
        send(mk(4'd7, 1, 16'h0100, 0, 0, 8'h00, 0, 5'b10001));
        check("jc_not_taken", o_exec_pc, 16'd4);
        send(mk(4'd7, 1, 16'h0100, 0, 0, 8'h00, 0, 5'b10010));
        check("jz_not_taken", o_exec_pc, 16'd5);

        // 0xFFFF + 1 -> 0 with C, Z, P set, then flag-driven jumps
        send(mk(4'd7, 1, 16'hFFFF, 0, 0, 8'h02, 0, 5'b0));
        send(mk(4'd0, 1, 16'h0001, 1, 0, 8'h01, 1, 5'b0));
        check("wrap_r0", dbg_r0, 16'h0);
        send(mk(4'd7, 1, 16'h0040, 0, 0, 8'h00, 0, 5'b10010));
        check("jz_taken", o_exec_pc, 16'h0040);
        send(mk(4'd7, 1, 16'h0080, 0, 0, 8'h00, 0, 5'b10001));
        check("jc_taken", o_exec_pc, 16'h0080);
        send(mk(4'd7, 1, 16'h0123, 0, 0, 8'h00, 0, 5'b11001));
        check("jp_taken", o_exec_pc, 16'h0123);
        send(mk(4'd7, 1, 16'h0200, 0, 0, 8'h00, 0, 5'b10011));
        check("jn_not_taken", o_exec_pc, 16'h0124);

        // load r4,r0 <- [r1+0x10]; an ack in the issue cycle must be ignored
        send(mk(4'd7, 1, 16'h0020, 0, 0, 8'h02, 0, 5'b0));
        x = mk(4'd0, 1, 16'h0010, 1, 0, 8'h11, 0, 5'b0);
        x.rd = 1'b1;
        apply(x); i_submit = 1'b1; i_mem_ack = 1'b1; i_mem_data = 16'h1111;
        step();
        i_submit = 1'b0; i_mem_ack = 1'b0;
        check("ld_ready", o_ready, 0);
        check("ld_req", o_mem_req, 1);
        check("ld_addr", o_mem_addr, 16'h0030);
        check("ld_we", o_mem_we, 0);
        step(); step();
        check("ld_req_held", o_mem_req, 1);
        check("ld_pc_held", o_exec_pc, 16'h0125);
        i_mem_ack = 1'b1; i_mem_data = 16'hBEEF;
        step();
        i_mem_ack = 1'b0;
        check("ld_r0", dbg_r0, 16'hBEEF);
        check("ld_done_req", o_mem_req, 0);
        check("ld_done_pc", o_exec_pc, 16'h0126);
        check("ld_done_upd", o_pc_update, 1);

        // store (rd and wr both set) with a second submit during MEM
        x = mk(4'd0, 1, 16'h0000, 1, 0, 8'h01, 0, 5'b0);
        x.rd = 1'b1; x.wr = 1'b1;
        send(x);
        check("st_we", o_mem_we, 1);
        check("st_addr", o_mem_addr, 16'h0020);
        check("st_data", o_mem_data, 16'hBEEF);
        x = mk(4'd7, 1, 16'h5555, 0, 0, 8'h01, 0, 5'b0);
        x.pc_ie = 1'b1;
        send(x);
        step();
        check("st_req_held", o_mem_req, 1);
        check("st_ignored_r0", dbg_r0, 16'hBEEF);
        check("st_ignored_pc", o_exec_pc, 16'h0126);
        i_mem_ack = 1'b1; i_mem_data = 16'h1234;
        step();
        i_mem_ack = 1'b0;
        check("st_no_write", dbg_r0, 16'hBEEF);
        check("st_pc", o_exec_pc, 16'h0127);

        // reset in the middle of a load, then a late ack
        x = mk(4'd0, 1, 16'h0000, 1, 0, 8'h01, 0, 5'b0);
        x.rd = 1'b1;
        send(x);
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("mrst_req", o_mem_req, 0);
        check("mrst_ready", o_ready, 1);
        check("mrst_pc", o_exec_pc, 16'h0);
        i_mem_ack = 1'b1; i_mem_data = 16'hDEAD;
        step();
        i_mem_ack = 1'b0;
        check("late_ack_pc", o_exec_pc, 16'h0);
        check("late_ack_r0", dbg_r0, 16'h0);
        check("late_ack_upd", o_pc_update, 0);

        // mode 8: 300*300
        send(mk(4'd7, 1, 16'd300, 0, 0, 8'h02, 0, 5'b0));
        send(mk(4'd7, 1, 16'd300, 0, 0, 8'h04, 0, 5'b0));
        send(mk(4'd8, 0, 16'd0, 1, 2, 8'h21, 1, 5'b0));
`ifdef EXECUTE_MUL_EN
        for (int k = 0; k < 16; k++) begin
            check("mul_busy", o_ready, 0);
            step();
        end
        check("mul_ready", o_ready, 1);
        check("mul_r0", dbg_r0, 16'h5F90);
        check("mul_pc", o_exec_pc, 16'd3);
        send(mk(4'd7, 1, 16'h0077, 0, 0, 8'h00, 0, 5'b10010));
        check("mul_jz", o_exec_pc, 16'd4);
`else
        check("mode8_ready", o_ready, 1);
        check("mode8_r0", dbg_r0, 16'h0);
        check("mode8_pc", o_exec_pc, 16'd3);
        send(mk(4'd7, 1, 16'h0077, 0, 0, 8'h00, 0, 5'b10010));
        check("mode8_jz", o_exec_pc, 16'h0077);
`endif

        // randomized phase
        for (int cyc = 0; cyc < 4000; cyc++) begin
            apply(rand_instr());
            i_rst      = ($urandom_range(0, 249) == 0);
            i_submit   = ($urandom_range(0, 9) < 6);
            i_mem_data = 16'($urandom);
            if (m_kind == 1) i_mem_ack = ($urandom_range(0, 2) == 0);
            else             i_mem_ack = ($urandom_range(0, 19) == 0);
            step();
        end
        i_submit = 1'b0; i_mem_ack = 1'b0; i_rst = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
